// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for an NxN output-stationary systolic array.
// Flow: fetch operands, feed skewed A/B wavefronts on the array edges, then
// stream the accumulated result rows out over a valid/ready port.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   start             job request (sampled only while idle)
//   busy, done        activity flag; one-cycle end-of-job pulse
//   op_rd_en/op_rd_k  operand fetch strobe and index k (data one cycle later)
//   op_a_col          lane i = A[i][k];  op_b_row: lane j = B[k][j]
//   arr_rst_n         reset for every PE (clears the accumulators)
//   a_edge/b_edge     west / north edge operands of the array
//   c_flat            PE(i,j) accumulator at slice i*N+j
//   res_row/res_idx   result row and its index, with res_valid/res_ready
//   job_cycles        cycle count of the last job
//
// Option: define SYSTOLIC_CTRL_PERF_EN to build the job_cycles counter;
// without it job_cycles is tied to zero.
module systolic_ctrl #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         op_rd_en,
    output logic [$clog2(N)-1:0]         op_rd_k,
    input  logic [N*DATA_WIDTH-1:0]      op_a_col,
    input  logic [N*DATA_WIDTH-1:0]      op_b_row,
    output logic                         arr_rst_n,
    output logic [N*DATA_WIDTH-1:0]      a_edge,
    output logic [N*DATA_WIDTH-1:0]      b_edge,
    input  logic [N*N*2*DATA_WIDTH-1:0]  c_flat,
    output logic [N*2*DATA_WIDTH-1:0]    res_row,
    output logic [$clog2(N)-1:0]         res_idx,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [15:0]                  job_cycles
);

    localparam int DW       = DATA_WIDTH;
    localparam int RW       = 2 * DATA_WIDTH;
    localparam int KW       = $clog2(N);
    localparam int FEED_LEN = 3 * N - 2;
    localparam int CW       = $clog2(FEED_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_READ,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   row_q, row_d;
    logic            arr_q, arr_d;
    logic            rd_vld_q, rd_vld_d;
    logic            feed;
    logic            fetch_feed;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_FEED;
                cnt_d   = '0;
            end
            S_FEED: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(FEED_LEN - 1)) begin
                    state_d = S_READ;
                    row_d   = '0;
                end
            end
            S_READ: begin
                if (res_ready) begin
                    if (row_q == KW'(N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign feed       = (state_q == S_FEED);
    // k=0 is fetched in CLEAR, k=1..N-1 in the first FEED cycles
    assign fetch_feed = feed && (cnt_q < CW'(N - 1));

    always_comb begin
        op_rd_en = (state_q == S_CLEAR) || fetch_feed;
        op_rd_k  = '0;
        if (fetch_feed) begin
            op_rd_k = KW'(cnt_q) + 1'b1;
        end
    end

    assign rd_vld_d = op_rd_en;
    assign arr_d    = (state_d != S_CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            row_q    <= '0;
            arr_q    <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            arr_q    <= arr_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign arr_rst_n = arr_q & rst;
    assign res_valid = (state_q == S_READ);
    assign res_idx   = res_valid ? row_q : '0;

    always_comb begin
        res_row = '0;
        if (res_valid) begin
            for (int r = 0; r < N; r++) begin
                if (row_q == KW'(r)) begin
                    res_row = c_flat[r*N*RW +: N*RW];
                end
            end
        end
    end

    // Edge lanes: fetched data is zeroed outside its return cycle, then lane
    // i is delayed by i cycles so the wavefront meets diagonally in the array.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DW-1:0] a_raw;
        logic [DW-1:0] b_raw;

        assign a_raw = rd_vld_q ? op_a_col[gi*DW +: DW] : '0;
        assign b_raw = rd_vld_q ? op_b_row[gi*DW +: DW] : '0;

        if (gi == 0) begin : g_direct
            assign a_edge[gi*DW +: DW] = feed ? a_raw : '0;
            assign b_edge[gi*DW +: DW] = feed ? b_raw : '0;
        end else begin : g_skew
            logic [DW-1:0] a_sr_q [gi];
            logic [DW-1:0] a_sr_d [gi];
            logic [DW-1:0] b_sr_q [gi];
            logic [DW-1:0] b_sr_d [gi];

            always_comb begin
                a_sr_d[0] = a_raw;
                b_sr_d[0] = b_raw;
                for (int d = 1; d < gi; d++) begin
                    a_sr_d[d] = a_sr_q[d-1];
                    b_sr_d[d] = b_sr_q[d-1];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int d = 0; d < gi; d++) begin
                        a_sr_q[d] <= '0;
                        b_sr_q[d] <= '0;
                    end
                end else begin
                    for (int d = 0; d < gi; d++) begin
                        a_sr_q[d] <= a_sr_d[d];
                        b_sr_q[d] <= b_sr_d[d];
                    end
                end
            end

            assign a_edge[gi*DW +: DW] = feed ? a_sr_q[gi-1] : '0;
            assign b_edge[gi*DW +: DW] = feed ? b_sr_q[gi-1] : '0;
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0] jc_q, jc_d;

    // Cleared on the way into CLEAR, counts CLEAR..DONE, then holds
    always_comb begin
        jc_d = jc_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                jc_d = '0;
            end
        end else begin
            jc_d = jc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jc_q <= '0;
        end else begin
            jc_q <= jc_d;
        end
    end

    assign job_cycles = jc_q;
`else
    assign job_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: randomized self-checking bench for systolic_ctrl with a
// behavioural operand memory and PE array around the controller.
module tb_systolic_ctrl;

    localparam int N    = 4;
    localparam int DW   = 10;
    localparam int RW   = 2 * DW;
    localparam int KW   = 2;
    localparam int MAXC = 64;
`ifdef SYSTOLIC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              res_ready = 1'b0;
    logic              busy, done, op_rd_en, arr_rst_n, res_valid;
    logic [KW-1:0]     op_rd_k, res_idx;
    logic [N*DW-1:0]   op_a_col, op_b_row, a_edge, b_edge;
    logic [N*N*RW-1:0] c_flat;
    logic [N*RW-1:0]   res_row;
    logic [15:0]       job_cycles;

    always #5 clk = ~clk;

    systolic_ctrl #(.N(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .op_rd_en(op_rd_en), .op_rd_k(op_rd_k),
        .op_a_col(op_a_col), .op_b_row(op_b_row),
        .arr_rst_n(arr_rst_n), .a_edge(a_edge), .b_edge(b_edge),
        .c_flat(c_flat), .res_row(res_row), .res_idx(res_idx),
        .res_valid(res_valid), .res_ready(res_ready),
        .job_cycles(job_cycles)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];

    // Operand memory: answers one cycle after a fetch, junk otherwise
    always @(posedge clk) begin
        logic [63:0] junk;
        if (op_rd_en) begin
            for (int i = 0; i < N; i++) begin
                op_a_col[i*DW +: DW] <= ma[i][op_rd_k];
                op_b_row[i*DW +: DW] <= mb[op_rd_k][i];
            end
        end else begin
            junk = {$urandom(), $urandom()};
            op_a_col <= junk[N*DW-1:0];
            junk = {$urandom(), $urandom()};
            op_b_row <= junk[N*DW-1:0];
        end
    end

    // PE array: a flows east, b flows south, C accumulates every cycle
    logic [RW-1:0] pe_c [N][N];
    logic [DW-1:0] pe_a [N][N];
    logic [DW-1:0] pe_b [N][N];
    logic [DW-1:0] a_w  [N][N];
    logic [DW-1:0] b_n  [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_w[i][0] = a_edge[i*DW +: DW];
            b_n[0][i] = b_edge[i*DW +: DW];
            for (int j = 1; j < N; j++) begin
                a_w[i][j] = pe_a[i][j-1];
                b_n[j][i] = pe_b[j-1][i];
            end
        end
    end

    always @(posedge clk or negedge arr_rst_n) begin
        if (!arr_rst_n) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pe_c[i][j] <= '0;
                    pe_a[i][j] <= '0;
                    pe_b[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pe_c[i][j] <= pe_c[i][j] + RW'(a_w[i][j]) * RW'(b_n[i][j]);
                    pe_a[i][j] <= a_w[i][j];
                    pe_b[i][j] <= b_n[i][j];
                end
        end
    end

    always_comb begin
        c_flat = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                c_flat[(i*N+j)*RW +: RW] = pe_c[i][j];
    end

    // Reference: plain matrix product modulo 2^RW
    function automatic logic [N*RW-1:0] model_row(input int r);
        logic [N*RW-1:0] v;
        longint s;
        v = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++)
                s += longint'(ma[r][k]) * longint'(mb[k][j]);
            v[j*RW +: RW] = s[RW-1:0];
        end
        return v;
    endfunction

    // Expected edges at cycle offset off from the start sample
    function automatic logic [N*DW-1:0] exp_a(input int off);
        logic [N*DW-1:0] v;
        int t;
        v = '0;
        t = off - 2;
        if (t >= 0 && t <= 3*N-3)
            for (int i = 0; i < N; i++)
                if (t - i >= 0 && t - i < N) v[i*DW +: DW] = ma[i][t-i];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input int off);
        logic [N*DW-1:0] v;
        int t;
        v = '0;
        t = off - 2;
        if (t >= 0 && t <= 3*N-3)
            for (int j = 0; j < N; j++)
                if (t - j >= 0 && t - j < N) v[j*DW +: DW] = mb[t-j][j];
        return v;
    endfunction

    // Per-cycle trace of one job, offset 0 = cycle start is sampled
    logic            t_busy  [MAXC];
    logic            t_done  [MAXC];
    logic            t_en    [MAXC];
    logic            t_arr   [MAXC];
    logic            t_valid [MAXC];
    logic [KW-1:0]   t_k     [MAXC];
    logic [KW-1:0]   t_idx   [MAXC];
    logic [N*DW-1:0] t_a     [MAXC];
    logic [N*DW-1:0] t_b     [MAXC];
    logic [N*RW-1:0] t_row   [MAXC];
    logic [15:0]     t_jc    [MAXC];
    logic [N*RW-1:0] got_row [N];
    int              n_got, done_off, n_off;
    bit              timeout;

    task automatic run_job(input bit hold, input bit already,
                           input int stall_row, input int stall_len);
        int stalled;
        bit fin;
        stalled  = 0;
        fin      = 1'b0;
        done_off = -1;
        n_got    = 0;
        n_off    = 0;
        timeout  = 1'b0;
        for (int r = 0; r < N; r++) got_row[r] = '0;
        if (!already) begin
            @(negedge clk);
            start = 1'b1;
        end
        for (int off = 0; off < MAXC && !fin; off++) begin
            if (off > 0) begin
                @(negedge clk);
                start = hold;
            end
            t_busy[off]  = busy;
            t_done[off]  = done;
            t_en[off]    = op_rd_en;
            t_k[off]     = op_rd_k;
            t_arr[off]   = arr_rst_n;
            t_valid[off] = res_valid;
            t_idx[off]   = res_idx;
            t_a[off]     = a_edge;
            t_b[off]     = b_edge;
            t_row[off]   = res_row;
            t_jc[off]    = job_cycles;
            n_off        = off + 1;
            res_ready    = 1'b1;
            if (res_valid && res_idx == KW'(stall_row) && stalled < stall_len) begin
                res_ready = 1'b0;
                stalled++;
            end
            if (res_valid && res_ready) begin
                got_row[res_idx] = res_row;
                n_got++;
            end
            if (done_off >= 0) fin = 1'b1;
            else if (done) done_off = off;
        end
        if (done_off < 0) timeout = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, op_rd_en, res_valid, arr_rst_n} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {busy, done, op_rd_en, res_valid, arr_rst_n});
        end
        checks++;
        if ({op_rd_k, res_idx, a_edge, b_edge, res_row, job_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_buses k=%0d idx=%0d a=%h b=%h row=%h jc=%0d exp=all zero",
                     op_rd_k, res_idx, a_edge, b_edge, res_row, job_cycles);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, arr_rst_n} !== 2'b01) begin
            errors++;
            $display("FAIL post_reset busy,arr_rst_n got=%b exp=01", {busy, arr_rst_n});
        end
    endtask

    task automatic test_identity;
        int fv, pulses;
        logic [15:0] ejc;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? DW'(1) : DW'(0);
                mb[i][j] = DW'(4*i + j + 1);
            end
        run_job(1'b0, 1'b0, 0, 0);
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL ident_timeout got=no done exp=done");
        end
        fv = -1;
        pulses = 0;
        for (int o = 0; o < n_off; o++) begin
            if (t_valid[o] && fv < 0) fv = o;
            if (t_done[o]) pulses++;
        end
        checks++;
        if (fv != 3*N) begin
            errors++;
            $display("FAIL ident_first_valid got=%0d exp=%0d", fv, 3*N);
        end
        checks++;
        if (done_off != 4*N || pulses != 1) begin
            errors++;
            $display("FAIL ident_done got=off%0d x%0d exp=off%0d x1", done_off, pulses, 4*N);
        end
        for (int o = 0; o < n_off; o++) begin
            checks++;
            if (t_en[o] !== (o >= 1 && o <= N) ||
                (t_en[o] && t_k[o] !== KW'(o - 1))) begin
                errors++;
                $display("FAIL ident_fetch off=%0d got=en%b k%0d exp=en%b k%0d",
                         o, t_en[o], t_k[o], (o >= 1 && o <= N), o - 1);
            end
            checks++;
            if (t_busy[o] !== (o >= 1 && o <= done_off) || t_arr[o] !== (o != 1)) begin
                errors++;
                $display("FAIL ident_busy_arr off=%0d got=%b%b exp=%b%b", o,
                         t_busy[o], t_arr[o], (o >= 1 && o <= done_off), (o != 1));
            end
            ejc = (PERF && o > 0) ? 16'(o - 1) : 16'd0;
            checks++;
            if (t_jc[o] !== ejc) begin
                errors++;
                $display("FAIL ident_job_cycles off=%0d got=%0d exp=%0d", o, t_jc[o], ejc);
            end
        end
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_row[r] !== model_row(r)) begin
                errors++;
                $display("FAIL ident_row%0d got=%h exp=%h", r, got_row[r], model_row(r));
            end
        end
        checks++;
        if (got_row[2][RW-1:0] !== RW'(9)) begin
            errors++;
            $display("FAIL ident_c20 got=%0d exp=9", got_row[2][RW-1:0]);
        end
    endtask

    task automatic test_random_edges;
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ma[i][j] = DW'($urandom_range(1023, 0));
                    mb[i][j] = DW'($urandom_range(1023, 0));
                end
            run_job(1'b0, 1'b0, 0, 0);
            checks++;
            if (done_off != 4*N) begin
                errors++;
                $display("FAIL rand_done got=%0d exp=%0d", done_off, 4*N);
            end
            for (int o = 0; o < n_off; o++) begin
                checks++;
                if (t_a[o] !== exp_a(o) || t_b[o] !== exp_b(o)) begin
                    errors++;
                    $display("FAIL rand_edge off=%0d got=%h/%h exp=%h/%h",
                             o, t_a[o], t_b[o], exp_a(o), exp_b(o));
                end
            end
            for (int r = 0; r < N; r++) begin
                checks++;
                if (got_row[r] !== model_row(r)) begin
                    errors++;
                    $display("FAIL rand_row%0d got=%h exp=%h", r, got_row[r], model_row(r));
                end
            end
        end
    endtask

    task automatic test_ones_max;
        logic [N*RW-1:0] e4, emax;
        for (int j = 0; j < N; j++) begin
            e4[j*RW +: RW]   = RW'(4);
            emax[j*RW +: RW] = RW'(1040388);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = DW'(1);
                mb[i][j] = DW'(1);
            end
        run_job(1'b0, 1'b0, 0, 0);
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_row[r] !== e4) begin
                errors++;
                $display("FAIL ones_row%0d got=%h exp=%h", r, got_row[r], e4);
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = DW'(1023);
                mb[i][j] = DW'(1023);
            end
        run_job(1'b0, 1'b0, 0, 0);
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_row[r] !== emax) begin
                errors++;
                $display("FAIL max_row%0d got=%h exp=%h", r, got_row[r], emax);
            end
        end
    endtask

    task automatic test_stall;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = DW'($urandom_range(1023, 0));
                mb[i][j] = DW'($urandom_range(1023, 0));
            end
        run_job(1'b0, 1'b0, 2, 5);
        checks++;
        if (done_off != 4*N + 5) begin
            errors++;
            $display("FAIL stall_done got=%0d exp=%0d", done_off, 4*N + 5);
        end
        for (int o = 3*N + 2; o <= 3*N + 7; o++) begin
            checks++;
            if (t_valid[o] !== 1'b1 || t_idx[o] !== KW'(2) || t_row[o] !== model_row(2)) begin
                errors++;
                $display("FAIL stall_hold off=%0d got=v%b i%0d %h exp=v1 i2 %h",
                         o, t_valid[o], t_idx[o], t_row[o], model_row(2));
            end
        end
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_row[r] !== model_row(r)) begin
                errors++;
                $display("FAIL stall_row%0d got=%h exp=%h", r, got_row[r], model_row(r));
            end
        end
        checks++;
        if (t_jc[n_off-1] !== (PERF ? 16'(4*N + 5) : 16'd0)) begin
            errors++;
            $display("FAIL stall_job_cycles got=%0d exp=%0d",
                     t_jc[n_off-1], PERF ? 4*N + 5 : 0);
        end
    endtask

    task automatic test_abort;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = DW'($urandom_range(1023, 0));
                mb[i][j] = DW'($urandom_range(1023, 0));
            end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || a_edge !== exp_a(7)) begin
            errors++;
            $display("FAIL abort_pre got=busy%b a=%h exp=busy1 a=%h", busy, a_edge, exp_a(7));
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, op_rd_en, res_valid, arr_rst_n} !== 5'b0 ||
            {op_rd_k, res_idx, a_edge, b_edge, res_row, job_cycles} !== '0) begin
            errors++;
            $display("FAIL abort_reset got=%b k%0d i%0d a=%h b=%h jc=%0d exp=all zero",
                     {busy, done, op_rd_en, res_valid, arr_rst_n},
                     op_rd_k, res_idx, a_edge, b_edge, job_cycles);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet c=%0d got=done%b busy%b exp=00", c, done, busy);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = DW'(1);
                mb[i][j] = DW'(1);
            end
        run_job(1'b0, 1'b0, 0, 0);
        checks++;
        if (done_off != 4*N) begin
            errors++;
            $display("FAIL abort_rerun_done got=%0d exp=%0d", done_off, 4*N);
        end
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_row[r] !== model_row(r)) begin
                errors++;
                $display("FAIL abort_rerun_row%0d got=%h exp=%h", r, got_row[r], model_row(r));
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = DW'($urandom_range(1023, 0));
                mb[i][j] = DW'($urandom_range(1023, 0));
            end
        run_job(1'b1, 1'b0, 0, 0);
        checks++;
        if (done_off != 4*N || t_busy[n_off-1] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got=done%0d busy%b exp=done%0d busy0",
                     done_off, t_busy[n_off-1], 4*N);
        end
        for (int r = 0; r < N; r++) begin
            checks++;
            if (got_row[r] !== model_row(r)) begin
                errors++;
                $display("FAIL b2b_job1_row%0d got=%h exp=%h", r, got_row[r], model_row(r));
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = (i == j) ? DW'(2) : DW'(0);
                mb[i][j] = DW'($urandom_range(1023, 0));
            end
        run_job(1'b0, 1'b1, 0, 0);
        checks++;
        if (t_busy[1] !== 1'b1 || t_arr[1] !== 1'b0 || done_off != 4*N) begin
            errors++;
            $display("FAIL b2b_launch got=busy%b arr%b done%0d exp=busy1 arr0 done%0d",
                     t_busy[1], t_arr[1], done_off, 4*N);
        end
        for (int r = 0; r < N; r++) begin
            logic [N*RW-1:0] e;
            for (int j = 0; j < N; j++) e[j*RW +: RW] = RW'(2 * int'(mb[r][j]));
            checks++;
            if (got_row[r] !== e) begin
                errors++;
                $display("FAIL b2b_job2_row%0d got=%h exp=%h", r, got_row[r], e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=no finish exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_identity();
        test_random_edges();
        test_ones_max();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning array dimension (NxN PEs, N>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 10, meaning operand width; result width RW = 2*DATA_WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  job request, sampled only in IDLE.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE.
REQ-007 SHALL have port done  output  1  one-cycle pulse at job end.
REQ-008 SHALL have port op_rd_en  output  1  operand fetch strobe; data returns exactly 1 cycle later.
REQ-009 SHALL have port op_rd_k  output  clog2(N)  fetch index k.
REQ-010 SHALL have port op_a_col  input  N*DATA_WIDTH  lane i = A[i][k].
REQ-011 SHALL have port op_b_row  input  N*DATA_WIDTH  lane j = B[k][j].
REQ-012 SHALL have port arr_rst_n  output  1  drives PE rst of every array PE.
REQ-013 SHALL have port a_edge  output  N*DATA_WIDTH  lane i drives west input a of PE(i,0).
REQ-014 SHALL have port b_edge  output  N*DATA_WIDTH  lane j drives north input b of PE(0,j).
REQ-015 SHALL have port c_flat  input  N*N*RW  PE(i,j) C_out at slice index i*N+j.
REQ-016 SHALL have ports res_row  output  N*RW (lane j = C[i][j]), res_idx  output  clog2(N) (row i), res_valid  output  1, res_ready  input  1.
REQ-017 SHALL have port job_cycles  output  16  performance count (see Configuration).

Function
REQ-018 SHALL implement states IDLE, CLEAR, FEED, READ, DONE; IDLE->CLEAR on start, CLEAR->FEED after 1 cycle, FEED->READ after 3N-2 cycles, READ->DONE after N accepted rows, DONE->IDLE after 1 cycle.
REQ-019 Timing: start sampled in cycle S; CLEAR = S+1; edge cycle t (0..3N-3) = cycle S+2+t; READ entered at S+3N.
REQ-020 arr_rst_n SHALL be registered low during CLEAR only, and forced low combinationally whenever rst is low.
REQ-021 op_rd_en SHALL be high with op_rd_k=k in cycle S+1+k for k=0..N-1, low otherwise.
REQ-022 In edge cycle t, a_edge lane i SHALL equal A[i][t-i] and b_edge lane j SHALL equal B[t-j][j] when index is in 0..N-1, else zero; skew realised by per-lane delay registers.
REQ-023 a_edge and b_edge SHALL be zero in every cycle outside FEED (PEs accumulate unconditionally).
REQ-024 In READ, res_valid SHALL be high, res_idx = current row, res_row = c_flat row res_idx; row advances only on res_valid&res_ready.
REQ-025 res_row/res_idx SHALL hold stable while res_valid&!res_ready, for unbounded stall.
REQ-026 Results SHALL be C_out modulo 2^RW; no saturation or overflow flag.
REQ-027 start while busy SHALL be ignored; start held high through DONE SHALL launch a new job from the following IDLE cycle.
REQ-028 done SHALL pulse in DONE, exactly one cycle after the last row handshake.

Reset
REQ-029 rst low SHALL asynchronously force IDLE, busy=0, done=0, op_rd_en=0, op_rd_k=0, a_edge=0, b_edge=0, res_valid=0, res_idx=0, res_row=0, job_cycles=0, arr_rst_n=0.
REQ-030 rst asserted mid-job SHALL abort with no done pulse; first start after release runs a complete fresh job.

Configuration
REQ-031 With SYSTOLIC_CTRL_PERF_EN defined, job_cycles SHALL clear on CLEAR entry, increment each busy cycle from CLEAR through DONE inclusive, and hold until next CLEAR.
REQ-032 Without SYSTOLIC_CTRL_PERF_EN, job_cycles SHALL be constant zero and no counter logic synthesised.

Verification
REQ-033 N=4, DW=10, A=identity, B[k][j]=4k+j+1, res_ready=1 -> rows 0..3 = B rows, res_valid first at S+12, done at S+16.
REQ-034 A, B all ones -> every C[i][j]=4; all-1023 -> every C[i][j]=1040388 (4186116 mod 2^20).
REQ-035 res_ready low 5 cycles on row 2 -> res_idx=2 and res_row stable 5 cycles, done delayed by 5 cycles.
REQ-036 rst low during edge cycle 5 -> all outputs reset values immediately; next job with all-ones yields 4 (no stale accumulation).
REQ-037 Two back-to-back jobs, second with A=2*identity -> second result exactly 2*B (CLEAR zeroed accumulators).
REQ-038 PERF_EN defined, res_ready=1 -> job_cycles=16 after done; undefined -> job_cycles=0 throughout.
